tea_xtea_core: RTL

Iterative, parametrised TEA/XTEA block-cipher engine: it encrypts or decrypts one 64-bit block per transaction. Rounds per clock, total cycle count and byte order are configurable. The algorithm (TEA or XTEA) and the direction are selected per transaction. It sits behind the existing TEA host interface and replaces the fixed 32-cycle, write-and-wait engine with a valid/ready streaming core that honours output backpressure.

---
 rtl/tea_pkg.sv | 19 +
 rtl/tea_xtea_core_if.sv | 24 ++
 rtl/tea_round.sv | 66 ++++++
 rtl/tea_xtea_core.sv | 103 ++++++++++
 4 files changed

// File: rtl/tea_pkg.sv
// rtl/tea_pkg.sv - shared constants, enums and helpers for the TEA/XTEA core
package tea_pkg;

    localparam logic [31:0] DELTA = 32'h9E37_79B9;

    typedef enum logic { MODE_ENC = 1'b0, MODE_DEC = 1'b1 } mode_e;
    typedef enum logic { ALG_TEA  = 1'b0, ALG_XTEA = 1'b1 } alg_e;

    // Reverses the byte order inside each 32-bit half independently.
    function automatic logic [63:0] bswap64(input logic [63:0] x);
        return {x[39:32], x[47:40], x[55:48], x[63:56],
                x[7:0],   x[15:8],  x[23:16], x[31:24]};
    endfunction

    function automatic int cnt_width(input int steps);
        return (steps <= 1) ? 1 : $clog2(steps);
    endfunction

endpackage

// File: rtl/tea_xtea_core_if.sv
// rtl/tea_xtea_core_if.sv - block input and result streams of the TEA/XTEA core
interface tea_xtea_core_if;

    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic [127:0] in_key;
    logic         in_mode;
    logic         in_alg;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;

    modport master (
        output in_valid, in_data, in_key, in_mode, in_alg, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_key, in_mode, in_alg, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/tea_round.sv
// rtl/tea_round.sv - one combinational Feistel cycle for TEA or XTEA, either direction
module tea_round
    import tea_pkg::*;
(
    input  logic [63:0]  v,
    input  logic [127:0] key,
    input  logic [31:0]  sum,
    input  alg_e         alg,
    input  mode_e        mode,
    output logic [63:0]  v_next,
    output logic [31:0]  sum_next
);

    logic [31:0] k [4];
    logic [31:0] v0, v1, v0_n, v1_n, s_a, s_b;

    assign k[0] = key[127:96];
    assign k[1] = key[95:64];
    assign k[2] = key[63:32];
    assign k[3] = key[31:0];
    assign v0   = v[63:32];
    assign v1   = v[31:0];
    assign v_next = {v0_n, v1_n};

    function automatic logic [31:0] tea_mix(input logic [31:0] x, s, ka, kb);
        return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
    endfunction

    function automatic logic [31:0] xtea_mix(input logic [31:0] x);
        return ((x << 4) ^ (x >> 5)) + x;
    endfunction

    // XTEA encrypt keeps s_a in the sum register, XTEA decrypt keeps s_b.
    always_comb begin
        s_a      = sum;
        s_b      = sum;
        v0_n     = v0;
        v1_n     = v1;
        sum_next = sum;
        case ({alg, mode})
            {ALG_TEA, MODE_ENC}: begin
                v0_n     = v0 + tea_mix(v1, sum, k[0], k[1]);
                v1_n     = v1 + tea_mix(v0_n, sum, k[2], k[3]);
                sum_next = sum + DELTA;
            end
            {ALG_TEA, MODE_DEC}: begin
                v1_n     = v1 - tea_mix(v0, sum, k[2], k[3]);
                v0_n     = v0 - tea_mix(v1_n, sum, k[0], k[1]);
                sum_next = sum - DELTA;
            end
            {ALG_XTEA, MODE_ENC}: begin
                s_b      = sum + DELTA;
                v0_n     = v0 + (xtea_mix(v1) ^ (s_a + k[s_a[1:0]]));
                v1_n     = v1 + (xtea_mix(v0_n) ^ (s_b + k[s_b[12:11]]));
                sum_next = s_b;
            end
            default: begin
                s_a      = sum - DELTA;
                v1_n     = v1 - (xtea_mix(v0) ^ (s_b + k[s_b[12:11]]));
                v0_n     = v0 - (xtea_mix(v1_n) ^ (s_a + k[s_a[1:0]]));
                sum_next = s_a;
            end
        endcase
    end

endmodule

// File: rtl/tea_xtea_core.sv
// rtl/tea_xtea_core.sv - iterative TEA/XTEA block engine with valid/ready streams
module tea_xtea_core
    import tea_pkg::*;
#(
    parameter int ROUNDS    = 32,
    parameter int UNROLL    = 1,
    parameter int SWAPBYTES = 1
) (
    input  logic            clk,
    input  logic            reset,
    tea_xtea_core_if.slave  bus
);

    localparam int          STEPS   = ROUNDS / UNROLL;
    localparam int          CNT_W   = cnt_width(STEPS);
    localparam logic [31:0] SUM_DEC = 32'(DELTA * 32'(ROUNDS));

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8) ||
        ROUNDS < 1 || ROUNDS > 64 || (ROUNDS % UNROLL) != 0) begin : g_bad_cfg
        $error("tea_xtea_core: illegal ROUNDS/UNROLL combination");
    end

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [63:0]      v_q;
    logic [127:0]     key_q;
    logic [31:0]      sum_q;
    mode_e            mode_q;
    alg_e             alg_q;
    logic [63:0]      data_in;

    logic [63:0] v_chain   [UNROLL+1];
    logic [31:0] sum_chain [UNROLL+1];

    assign v_chain[0]   = v_q;
    assign sum_chain[0] = sum_q;

    for (genvar u = 0; u < UNROLL; u++) begin : g_round
        tea_round u_round (
            .v        (v_chain[u]),
            .key      (key_q),
            .sum      (sum_chain[u]),
            .alg      (alg_q),
            .mode     (mode_q),
            .v_next   (v_chain[u+1]),
            .sum_next (sum_chain[u+1])
        );
    end

    assign data_in       = (SWAPBYTES != 0) ? bswap64(bus.in_data) : bus.in_data;
    assign bus.in_ready  = (state == S_IDLE) && !reset;
    assign bus.out_valid = (state == S_DONE);
    assign bus.out_data  = (SWAPBYTES != 0) ? bswap64(v_q) : v_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            v_q    <= '0;
            key_q  <= '0;
            sum_q  <= '0;
            mode_q <= MODE_ENC;
            alg_q  <= ALG_TEA;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        state  <= S_RUN;
                        cnt    <= '0;
                        v_q    <= data_in;
                        key_q  <= bus.in_key;
                        mode_q <= mode_e'(bus.in_mode);
                        alg_q  <= alg_e'(bus.in_alg);
                        if (bus.in_mode)
                            sum_q <= SUM_DEC;
                        else if (bus.in_alg)
                            sum_q <= '0;
                        else
                            sum_q <= DELTA;
                    end
                end
                S_RUN: begin
                    v_q   <= v_chain[UNROLL];
                    sum_q <= sum_chain[UNROLL];
                    if (cnt == CNT_W'(STEPS - 1))
                        state <= S_DONE;
                    else
                        cnt <= cnt + CNT_W'(1);
                end
                S_DONE: begin
                    if (bus.out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
